data_mem_lsu: RTL and testbench
===============================

// Module: data_mem_lsu
// PURPOSE
//  Parametrised byte-addressed data memory with built-in load/store alignment for the RISC-V core.
//  Supports LB/LH/LW/LBU/LHU/SB/SH/SW, a valid/ready request and response handshake, and a configurable read latency.
//  Misaligned and out-of-range accesses produce an error response instead of a memory access.
//  Includes an optional zero-fill sweep after reset.
//  Sits between the core's memory stage and the writeback mux, replacing the fixed word-array data memory.
// PARAMETERS
//  DEPTH_WORDS  1024  number of 32-bit words; power of 2, 16..65536
//  RD_LAT       1     cycles from request accept to response valid; 1..4
//  CLEAR_ON_RST 0     1: zero every word after reset release before accepting requests
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous, active-low reset
//  req_valid    in   1   request present
//  req_ready    out  1   request can be accepted this cycle
//  req_we       in   1   1 = store, 0 = load
//  req_size     in   2   00 byte, 01 half, 10 word, 11 illegal (error)
//  req_unsigned in   1   loads only: 1 = zero-extend, 0 = sign-extend
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, right-justified (byte in [7:0], half in [15:0])
//  rsp_valid    out  1   response present
//  rsp_ready    in   1   consumer accepts response
//  rsp_rdata    out  32  load data, extended to 32 bits; 0 for stores and errors
//  rsp_err      out  1   misaligned, out-of-range or illegal-size request
//  busy         out  1   clear sweep in progress
// BEHAVIOUR
//  - Reset (rst=0, asynchronous): pipeline valid bits, rsp_valid, rsp_err, rsp_rdata and busy are cleared to 0; req_ready is 0.
//  - Reset does not modify the array. A reset mid-operation drops all in-flight requests with no response.
//  - FSM states, encoded in the package:
//    - CLEAR: entered on reset release if CLEAR_ON_RST=1; otherwise go straight to RUN.
//    - CLEAR writes 0 to word index 0..DEPTH_WORDS-1, one word per cycle, with busy=1 and req_ready=0.
//    - CLEAR moves to RUN after writing the last index.
//    - RUN: normal operation; there is no exit except reset.
//  - Accept: a request is accepted when req_valid && req_ready.
//  - In RUN, req_ready = !stall, where stall = rsp_valid && !rsp_ready.
//  - Error check at accept; any of these sets err:
//    - size 01 with addr[0]!=0
//    - size 10 with addr[1:0]!=0
//    - size 11
//    - addr[31:2] >= DEPTH_WORDS
//  - Stores: on accept with no error, write only the enabled byte lanes of word addr[..:2] at that clock edge.
//    - Byte lane = addr[1:0]; a half store uses lanes addr[1]*2 and addr[1]*2+1.
//    - An erroring store writes nothing.
//  - Loads: read the word, select lanes by addr[1:0], then extend per req_unsigned.
//  - Every accepted request yields exactly one response, strictly in order, RD_LAT cycles later if no stall.
//  - While stalled, the whole pipeline holds and rsp_* stay stable.
//  - Ordering: a load accepted in any cycle after a store's accept sees that store's data (write-before-read).
//  - Throughput: one request per cycle when rsp_ready=1.
//  - rsp_rdata=0 whenever rsp_err=1 or for stores. rsp_* hold their last values when rsp_valid=0; the bench ignores them then.
// STRUCTURE
//  - Package data_mem_pkg: size encodings (SZ_B, SZ_H, SZ_W), FSM state enum (CLEAR, RUN), byte-enable function be_of(size, addr[1:0]).
//  - Sub-module data_mem_align: combinational load lane select plus sign/zero extend, and store data replication to lanes.
//  - Top level holds: the array, the FSM and clear counter, the RD_LAT-deep valid/data/err pipeline, and stall logic.
// TESTING
//  - CLEAR_ON_RST=1, DEPTH_WORDS=16:
//    - after reset release, busy=1 and req_ready=0 for exactly 16 cycles, then req_ready=1;
//    - LW 0x3C then returns 0.
//  - SW 0x11223344 to 0x20; SB 0xAA to 0x21; then:
//    - LW 0x20 -> 0x1122AA44
//    - LB 0x21 -> 0xFFFFFFAA
//    - LBU 0x21 -> 0x000000AA
//    - LH 0x22 -> 0x00001122
//  - LH 0x21 -> rsp_err=1, rdata=0.
//  - SW to addr DEPTH_WORDS*4 -> rsp_err=1; array unchanged (LW 0 still returns its old value).
//  - RD_LAT=3, back-to-back LW 0x0,0x4,0x8 with rsp_ready=1:
//    - responses arrive on cycles +3,+4,+5, in order.
//  - RD_LAT=3, hold rsp_ready=0 for 5 cycles mid-stream:
//    - req_ready=0 while stalled; no response lost or duplicated; rsp_* stable.
//  - Reset asserted with 2 loads in flight:
//    - no response after release; the array retains earlier stored data (CLEAR_ON_RST=0).

Source files
------------

// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared encodings and helpers for the data memory LSU
//
// Purpose: access-size encodings, controller state type and the byte-enable
//          helper used by data_mem_lsu and data_mem_align.
// Ports:   none (package)
package data_mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Byte lanes touched by an access of the given size at byte offset lane.
  // Alignment is checked separately; a misaligned half still maps onto its
  // containing half-word here, which is harmless because errors never write.
  function automatic logic [3:0] be_of(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << lane;
      SZ_H:    be = lane[1] ? 4'b1100 : 4'b0011;
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/data_mem_align.sv
// rtl/data_mem_align.sv - load lane select/extend and store lane replication
//
// Purpose: purely combinational alignment datapath.
// Ports:
//   i_size     [1:0]  access size (SZ_B/SZ_H/SZ_W)
//   i_unsigned        1 = zero-extend loads, 0 = sign-extend
//   i_lane     [1:0]  byte offset within the word
//   i_rword    [31:0] raw word read from the array
//   i_wdata    [31:0] right-justified store data
//   o_ldata    [31:0] extended load result
//   o_wword    [31:0] store data replicated onto every candidate lane
module data_mem_align
  import data_mem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_rword,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_ldata,
  output logic [31:0] o_wword
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rword >> {i_lane, 3'b000};

  always_comb begin
    o_ldata = 32'h0;
    case (i_size)
      SZ_B:    o_ldata = i_unsigned ? {24'h0, w_shifted[7:0]}
                                    : {{24{w_shifted[7]}}, w_shifted[7:0]};
      SZ_H:    o_ldata = i_unsigned ? {16'h0, w_shifted[15:0]}
                                    : {{16{w_shifted[15]}}, w_shifted[15:0]};
      SZ_W:    o_ldata = i_rword;
      default: o_ldata = 32'h0;
    endcase
  end

  // Replication lets the byte enables alone pick which lanes land in memory.
  always_comb begin
    o_wword = i_wdata;
    case (i_size)
      SZ_B:    o_wword = {4{i_wdata[7:0]}};
      SZ_H:    o_wword = {2{i_wdata[15:0]}};
      default: o_wword = i_wdata;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// rtl/data_mem_lsu.sv - byte-addressed data memory with load/store alignment
//
// Purpose: data memory for the core's memory stage; handles LB/LH/LW/LBU/LHU/
//          SB/SH/SW with valid/ready handshakes, RD_LAT-cycle responses and an
//          optional zero-fill sweep after reset.
// Ports:
//   clk, rst (async active-low)
//   req_valid/req_ready, req_we, req_size[1:0], req_unsigned,
//   req_addr[31:0], req_wdata[31:0]          request channel
//   rsp_valid/rsp_ready, rsp_rdata[31:0], rsp_err   response channel
//   busy                                      clear sweep in progress
module data_mem_lsu #(
  parameter int DEPTH_WORDS  = 1024,
  parameter int RD_LAT       = 1,
  parameter int CLEAR_ON_RST = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);
  import data_mem_pkg::*;

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

  logic [31:0]      r_mem [DEPTH_WORDS];

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_started;
  logic [IDX_W-1:0] r_clr_idx;
  logic             w_clr_we;

  logic             r_vld [RD_LAT];
  logic             r_err [RD_LAT];
  logic [31:0]      r_dat [RD_LAT];

  logic             w_stall;
  logic             w_accept;
  logic             w_err;
  logic [29:0]      w_word;
  logic [IDX_W-1:0] w_idx;
  logic [3:0]       w_be;
  logic [31:0]      w_rword;
  logic [31:0]      w_ldata;
  logic [31:0]      w_wword;

  assign rsp_valid = r_vld[RD_LAT-1];
  assign rsp_err   = r_err[RD_LAT-1];
  assign rsp_rdata = r_dat[RD_LAT-1];

  assign w_stall  = rsp_valid && !rsp_ready;
  assign w_accept = req_valid && req_ready;

  assign w_word = req_addr[31:2];
  assign w_idx  = req_addr[IDX_W+1:2];
  assign w_be   = be_of(req_size, req_addr[1:0]);

  assign w_err = (req_size == SZ_X)
              || ((req_size == SZ_H) && req_addr[0])
              || ((req_size == SZ_W) && (req_addr[1:0] != 2'b00))
              || (w_word >= 30'(DEPTH_WORDS));

  // Asynchronous read at accept: a store accepted on the previous edge is
  // already in the array, giving write-before-read ordering for free.
  assign w_rword = r_mem[w_idx];

  data_mem_align u_align (
    .i_size     (req_size),
    .i_unsigned (req_unsigned),
    .i_lane     (req_addr[1:0]),
    .i_rword    (w_rword),
    .i_wdata    (req_wdata),
    .o_ldata    (w_ldata),
    .o_wword    (w_wword)
  );

  // r_started keeps req_ready/busy low during reset and for the single
  // decision cycle right after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= CLEAR;
      r_started <= 1'b0;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_started <= 1'b1;
      if (w_clr_we) begin
        r_clr_idx <= r_clr_idx + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr_we    = 1'b0;
    req_ready   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      CLEAR: begin
        if (!r_started) begin
          w_state_nxt = (CLEAR_ON_RST != 0) ? CLEAR : RUN;
        end else begin
          busy     = 1'b1;
          w_clr_we = 1'b1;
          if (r_clr_idx == LAST_IDX) begin
            w_state_nxt = RUN;
          end
        end
      end
      RUN: begin
        req_ready = !w_stall;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  // The array is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_idx] <= 32'h0;
    end else if (w_accept && req_we && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][b*8 +: 8] <= w_wword[b*8 +: 8];
        end
      end
    end
  end

  // Stage data only moves with a valid entry so the output stage keeps its
  // last values once the response has been consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_vld[i] <= 1'b0;
        r_err[i] <= 1'b0;
        r_dat[i] <= 32'h0;
      end
    end else if (!w_stall) begin
      r_vld[0] <= w_accept;
      if (w_accept) begin
        r_err[0] <= w_err;
        r_dat[0] <= (!req_we && !w_err) ? w_ldata : 32'h0;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) begin
          r_err[i] <= r_err[i-1];
          r_dat[i] <= r_dat[i-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb/tb_data_mem_lsu.sv - self-checking bench for data_mem_lsu
module tb_data_mem_lsu;
  import data_mem_pkg::*;

  localparam int DEPTH = 16;
  localparam int LAT_A = 3;
  localparam int LAT_B = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, va, vb, rr_a, rr_b;
  logic        we, uns;
  logic [1:0]  sz;
  logic [31:0] addr, wdata;
  logic        rdy_a, rv_a, er_a, busy_a;
  logic        rdy_b, rv_b, er_b, busy_b;
  logic [31:0] rd_a, rd_b;

  data_mem_lsu #(.DEPTH_WORDS(DEPTH), .RD_LAT(LAT_A), .CLEAR_ON_RST(1)) u_dut_a (
    .clk(clk), .rst(rst_a), .req_valid(va), .req_ready(rdy_a), .req_we(we),
    .req_size(sz), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
    .rsp_valid(rv_a), .rsp_ready(rr_a), .rsp_rdata(rd_a), .rsp_err(er_a), .busy(busy_a)
  );

  data_mem_lsu #(.DEPTH_WORDS(DEPTH), .RD_LAT(LAT_B), .CLEAR_ON_RST(0)) u_dut_b (
    .clk(clk), .rst(rst_b), .req_valid(vb), .req_ready(rdy_b), .req_we(we),
    .req_size(sz), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
    .rsp_valid(rv_b), .rsp_ready(rr_b), .rsp_rdata(rd_b), .rsp_err(er_b), .busy(busy_b)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] acc;
  } exp_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          stall_req_n = 0;
  bit          rand_rr = 1'b0;
  bit          lat_chk_a = 1'b0;
  exp_t        qa[$];
  exp_t        qb[$];
  exp_t        ea, eb;
  logic [7:0]  model [2][64] = '{default: 8'h00};
  logic        hold_v_a = 1'b0;
  logic        hold_e;
  logic [31:0] hold_d;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: memory as a flat byte array, little-endian.
  function automatic exp_t model_op(input int inst, input bit w, input logic [1:0] s,
                                    input bit u, input logic [31:0] a,
                                    input logic [31:0] d, input int c);
    exp_t        e;
    int          n;
    logic [31:0] v;
    e.acc   = 32'(c);
    e.rdata = 32'h0;
    e.err   = 1'b0;
    n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    if (s == 2'd3 || (a % n) != 0 || a >= DEPTH * 4) begin
      e.err = 1'b1;
      return e;
    end
    if (w) begin
      for (int k = 0; k < n; k++) model[inst][a + k] = d[8*k +: 8];
    end else begin
      v = 32'h0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = model[inst][a + k];
      if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      e.rdata = v;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_a) begin
      hold_v_a = 1'b0;
    end else begin
      if (hold_v_a) begin
        chk("stall_hold_valid", rv_a, 1);
        chk("stall_hold_rdata", rd_a, hold_d);
        chk("stall_hold_err", er_a, hold_e);
      end
      hold_v_a = rv_a && !rr_a;
      if (hold_v_a) begin
        hold_d = rd_a;
        hold_e = er_a;
        chk("stall_req_ready_low", rdy_a, 0);
      end
      if (rv_a && rr_a) begin
        chk("rsp_a_expected", 32'(qa.size() > 0), 1);
        if (qa.size() > 0) begin
          ea = qa.pop_front();
          chk("rsp_a_rdata", rd_a, ea.rdata);
          chk("rsp_a_err", er_a, ea.err);
          if (lat_chk_a) chk("rsp_a_latency", 32'(cyc) - ea.acc, LAT_A);
        end
      end
      if (va && rdy_a) qa.push_back(model_op(0, we, sz, uns, addr, wdata, cyc));
    end
  end

  always @(negedge clk) begin
    if (!rst_b) begin
      qb.delete();
    end else begin
      if (rv_b) begin
        chk("rsp_b_expected", 32'(qb.size() > 0), 1);
        if (qb.size() > 0) begin
          eb = qb.pop_front();
          chk("rsp_b_rdata", rd_b, eb.rdata);
          chk("rsp_b_err", er_b, eb.err);
          chk("rsp_b_latency", 32'(cyc) - eb.acc, LAT_B);
        end
      end
      if (vb && rdy_b) qb.push_back(model_op(1, we, sz, uns, addr, wdata, cyc));
    end
  end

  // Response-side driver: 5-cycle stall on request, random back-pressure or always ready.
  initial begin
    int seen;
    int left;
    seen = 0;
    left = 0;
    rr_a = 1'b1;
    rr_b = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (stall_req_n != seen) begin
        seen = stall_req_n;
        left = 5;
      end
      if (left > 0) begin
        rr_a = 1'b0;
        left--;
      end else if (rand_rr) begin
        rr_a = ($urandom_range(0, 3) != 0);
      end else begin
        rr_a = 1'b1;
      end
    end
  end

  task automatic issue(input bit to_b, input bit w, input logic [1:0] s, input bit u,
                       input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    we = w; sz = s; uns = u; addr = a; wdata = d;
    if (to_b) vb = 1'b1; else va = 1'b1;
    forever begin
      @(negedge clk);
      if (to_b ? rdy_b : rdy_a) break;
      n++;
      if (n > 200) begin
        chk("accept_timeout_cycles", 32'(n), 32'(200));
        break;
      end
    end
    @(posedge clk);
    #1;
    va = 1'b0;
    vb = 1'b0;
  endtask

  task automatic drain(input bit to_b);
    int n;
    n = 0;
    while ((to_b ? qb.size() : qa.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(to_b ? "drain_b" : "drain_a", 32'(to_b ? qb.size() : qa.size()), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    int nb;
    rst_a = 1'b0; rst_b = 1'b0; va = 1'b0; vb = 1'b0;
    we = 1'b0; sz = SZ_B; uns = 1'b0; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_rsp_valid", rv_a, 0);
    chk("rst_a_req_ready", rdy_a, 0);
    chk("rst_a_busy", busy_a, 0);
    chk("rst_a_rdata", rd_a, 0);
    chk("rst_a_err", er_a, 0);
    chk("rst_b_rsp_valid", rv_b, 0);
    chk("rst_b_req_ready", rdy_b, 0);
    chk("rst_b_busy", busy_b, 0);
    @(posedge clk);
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;

    w = 0;
    while (!busy_a && w < 10) begin
      @(negedge clk);
      w++;
    end
    nb = 0;
    while (busy_a && nb < 100) begin
      chk("clear_req_ready_low", rdy_a, 0);
      nb++;
      @(negedge clk);
    end
    chk("clear_busy_cycles", 32'(nb), 32'(DEPTH));
    chk("clear_done_req_ready", rdy_a, 1);
    chk("b_no_clear_busy", busy_b, 0);
    chk("b_ready_after_release", rdy_b, 1);
    @(posedge clk);
    #1;

    // Directed accesses, back-to-back, latency checked.
    lat_chk_a = 1'b1;
    issue(0, 0, SZ_W, 0, 32'h3C, 32'h0);
    drain(0);
    issue(0, 1, SZ_W, 0, 32'h20, 32'h1122_3344);
    issue(0, 1, SZ_B, 0, 32'h21, 32'h0000_00AA);
    issue(0, 0, SZ_W, 0, 32'h20, 32'h0);
    issue(0, 0, SZ_B, 0, 32'h21, 32'h0);
    issue(0, 0, SZ_B, 1, 32'h21, 32'h0);
    issue(0, 0, SZ_H, 0, 32'h22, 32'h0);
    issue(0, 0, SZ_H, 0, 32'h21, 32'h0);
    issue(0, 1, SZ_W, 0, 32'(DEPTH * 4), 32'h5555_AAAA);
    issue(0, 0, SZ_W, 0, 32'h0, 32'h0);
    issue(0, 0, SZ_X, 0, 32'h8, 32'h0);
    drain(0);
    issue(0, 0, SZ_W, 0, 32'h0, 32'h0);
    issue(0, 0, SZ_W, 0, 32'h4, 32'h0);
    issue(0, 0, SZ_W, 0, 32'h8, 32'h0);
    drain(0);

    // Mid-stream stall of 5 cycles.
    lat_chk_a = 1'b0;
    issue(0, 1, SZ_H, 0, 32'h4, 32'h0000_8001);
    issue(0, 0, SZ_H, 0, 32'h4, 32'h0);
    stall_req_n++;
    issue(0, 0, SZ_W, 0, 32'h20, 32'h0);
    issue(0, 0, SZ_B, 0, 32'h20, 32'h0);
    issue(0, 0, SZ_H, 1, 32'h4, 32'h0);
    issue(0, 0, SZ_B, 0, 32'h5, 32'h0);
    drain(0);

    // Random traffic with random back-pressure.
    rand_rr = 1'b1;
    for (int i = 0; i < 80; i++) begin
      issue(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 79)), $urandom);
    end
    drain(0);
    rand_rr = 1'b0;

    // Reset with two loads in flight on the non-clearing instance.
    issue(1, 1, SZ_W, 0, 32'h0, 32'hDEAD_BEEF);
    issue(1, 1, SZ_H, 0, 32'h6, 32'h0000_CAFE);
    drain(1);
    issue(1, 0, SZ_W, 0, 32'h0, 32'h0);
    issue(1, 0, SZ_W, 0, 32'h4, 32'h0);
    rst_b = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("b_inreset_rsp_valid", rv_b, 0);
      chk("b_inreset_req_ready", rdy_b, 0);
    end
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("b_no_rsp_after_reset", rv_b, 0);
    end
    @(posedge clk);
    #1;
    issue(1, 0, SZ_W, 0, 32'h0, 32'h0);
    issue(1, 0, SZ_H, 1, 32'h6, 32'h0);
    issue(1, 0, SZ_H, 0, 32'h6, 32'h0);
    drain(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
